dma_bus_arbiter: RTL and testbench



---
 rtl/k580_pkg.sv | 20 ++
 rtl/arb_sat_counter.sv | 35 +++
 rtl/dma_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/k580_pkg.sv
// Shared types and constants for the K580 bus arbitration slice.
package k580_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned GUARD_W = 3;
  localparam int unsigned STAT_W  = 16;

  // Bus address type shared with the CPU and DMA wrappers.
  typedef logic [ADDR_W-1:0] bus_addr_t;

  // Bus ownership phases.
  typedef enum logic [2:0] {
    ARB_CPU    = 3'd0,
    ARB_DRAIN  = 3'd1,
    ARB_SETTLE = 3'd2,
    ARB_DMA    = 3'd3,
    ARB_RETURN = 3'd4
  } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// 16-bit saturating event counter with synchronous clear (clear wins over enable).
// Ports: clk_i, rst_i (async, active-high), clr_i, en_i, count_o.
module arb_sat_counter
  import k580_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [STAT_W-1:0] count_o
);

  logic [STAT_W-1:0] count_q, count_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// Memory bus arbiter between the K580VM80A CPU and the K580VT57 DMA controller.
// Converts HRQ into a CPU hold, drains the CPU cycle, inserts a GUARD-tick idle
// gap around each owner change, muxes address/strobes and counts stolen ticks.
// Ports: clk, reset (async, active-high), ce; CPU side cpu_addr/cpu_wr_n/cpu_rd_n/
// cpu_busy/cpu_hold; DMA side dma_hrq/dma_hlda/dma_addr/dma_wr_n/dma_rd_n;
// memory side mem_addr/mem_wr_n/mem_rd_n; dma_owner; stat_clr/stat_stolen.
module dma_bus_arbiter
  import k580_pkg::*;
#(
  parameter int unsigned GUARD = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  bus_addr_t         cpu_addr,
  input  logic              cpu_wr_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_busy,
  output logic              cpu_hold,
  input  logic              dma_hrq,
  output logic              dma_hlda,
  input  bus_addr_t         dma_addr,
  input  logic              dma_wr_n,
  input  logic              dma_rd_n,
  output bus_addr_t         mem_addr,
  output logic              mem_wr_n,
  output logic              mem_rd_n,
  output logic              dma_owner,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_stolen
);

  localparam logic [GUARD_W-1:0] GUARD_L = GUARD_W'(GUARD);

  arb_state_t         state_q, state_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               cpu_hold_q, dma_hlda_q, dma_owner_q;

  // Next-state and guard countdown; guard holds remaining idle ticks.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    if (ce) begin
      unique case (state_q)
        ARB_CPU: begin
          if (dma_hrq) state_d = ARB_DRAIN;
        end
        ARB_DRAIN: begin
          if (!dma_hrq) begin
            state_d = ARB_CPU;
          end else if (!cpu_busy) begin
            if (GUARD_L == '0) begin
              state_d = ARB_DMA;
            end else begin
              state_d = ARB_SETTLE;
              guard_d = GUARD_L;
            end
          end
        end
        ARB_SETTLE: begin
          if (!dma_hrq) begin
            state_d = ARB_CPU;
            guard_d = '0;
          end else if (guard_q <= GUARD_W'(1)) begin
            state_d = ARB_DMA;
            guard_d = '0;
          end else begin
            guard_d = guard_q - GUARD_W'(1);
          end
        end
        ARB_DMA: begin
          if (!dma_hrq) begin
            if (GUARD_L == '0) begin
              state_d = ARB_CPU;
            end else begin
              state_d = ARB_RETURN;
              guard_d = GUARD_L;
            end
          end
        end
        ARB_RETURN: begin
          // A fresh HRQ is not looked at until ARB_CPU is re-entered.
          if (guard_q <= GUARD_W'(1)) begin
            state_d = ARB_CPU;
            guard_d = '0;
          end else begin
            guard_d = guard_q - GUARD_W'(1);
          end
        end
        default: begin
          state_d = ARB_CPU;
          guard_d = '0;
        end
      endcase
    end
  end

  // State, guard and handshake outputs; outputs are decoded from the next state
  // so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_CPU;
      guard_q     <= '0;
      cpu_hold_q  <= 1'b0;
      dma_hlda_q  <= 1'b0;
      dma_owner_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      cpu_hold_q  <= (state_d != ARB_CPU);
      dma_hlda_q  <= (state_d == ARB_DMA);
      dma_owner_q <= (state_d inside {ARB_SETTLE, ARB_DMA, ARB_RETURN});
    end
  end

  assign cpu_hold  = cpu_hold_q;
  assign dma_hlda  = dma_hlda_q;
  assign dma_owner = dma_owner_q;

  // Address follows the registered owner; it only flips while strobes are idle.
  assign mem_addr = dma_owner_q ? dma_addr : cpu_addr;

  // Strobe mux; both strobes are parked high in the guard phases.
  always_comb begin
    mem_wr_n = 1'b1;
    mem_rd_n = 1'b1;
    case (state_q)
      ARB_CPU, ARB_DRAIN: begin
        mem_wr_n = cpu_wr_n;
        mem_rd_n = cpu_rd_n;
      end
      ARB_DMA: begin
        mem_wr_n = dma_wr_n;
        mem_rd_n = dma_rd_n;
      end
      default: begin
        mem_wr_n = 1'b1;
        mem_rd_n = 1'b1;
      end
    endcase
  end

  arb_sat_counter u_stolen (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (ce & stat_clr),
    .en_i    (ce & (state_q == ARB_DMA)),
    .count_o (stat_stolen)
  );

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter (GUARD=1) against a behavioural
// ownership model: hold/grant flags plus an idle-gap countdown.
module tb_dma_bus_arbiter;

  localparam int G = 1;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [15:0] cpu_addr, dma_addr;
  logic        cpu_wr_n, cpu_rd_n, cpu_busy, dma_hrq, dma_wr_n, dma_rd_n, stat_clr;
  logic        cpu_hold, dma_hlda, dma_owner, mem_wr_n, mem_rd_n;
  logic [15:0] mem_addr, stat_stolen;

  int vectors = 0;
  int miscompares = 0;

  // Model: hold requested, bus granted, returning, idle gap ticks left, stolen ticks.
  bit m_hold, m_grant, m_ret;
  int m_gap, m_stolen;

  dma_bus_arbiter #(.GUARD(G)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_wr_n(cpu_wr_n), .cpu_rd_n(cpu_rd_n),
    .cpu_busy(cpu_busy), .cpu_hold(cpu_hold),
    .dma_hrq(dma_hrq), .dma_hlda(dma_hlda), .dma_addr(dma_addr),
    .dma_wr_n(dma_wr_n), .dma_rd_n(dma_rd_n),
    .mem_addr(mem_addr), .mem_wr_n(mem_wr_n), .mem_rd_n(mem_rd_n),
    .dma_owner(dma_owner), .stat_clr(stat_clr), .stat_stolen(stat_stolen)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_hold = 0; m_grant = 0; m_ret = 0; m_gap = 0; m_stolen = 0;
  endfunction

  function automatic bit m_owner();
    return m_grant || (m_gap > 0);
  endfunction

  function automatic logic [15:0] exp_addr();
    return m_owner() ? dma_addr : cpu_addr;
  endfunction

  function automatic logic exp_rd_n();
    if (m_gap > 0) return 1'b1;
    return m_grant ? dma_rd_n : cpu_rd_n;
  endfunction

  function automatic logic exp_wr_n();
    if (m_gap > 0) return 1'b1;
    return m_grant ? dma_wr_n : cpu_wr_n;
  endfunction

  // Advance one clock edge and the model; outputs are then stable 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (ce) begin
      if (stat_clr) m_stolen = 0;
      else if (m_grant && m_stolen < 65535) m_stolen++;
      if (!m_hold) begin
        m_hold = dma_hrq;
      end else if (m_grant) begin
        if (!dma_hrq) begin
          m_grant = 0;
          if (G == 0) m_hold = 0;
          else begin m_ret = 1; m_gap = G; end
        end
      end else if (m_ret) begin
        m_gap--;
        if (m_gap == 0) begin m_ret = 0; m_hold = 0; end
      end else if (m_gap > 0) begin
        if (!dma_hrq) begin m_gap = 0; m_hold = 0; end
        else begin m_gap--; if (m_gap == 0) m_grant = 1; end
      end else begin
        if (!dma_hrq) m_hold = 0;
        else if (!cpu_busy) begin
          if (G == 0) m_grant = 1; else m_gap = G;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    ce = 1; cpu_wr_n = 1; cpu_rd_n = 1; cpu_busy = 0; dma_hrq = 0;
    dma_wr_n = 1; dma_rd_n = 1; stat_clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; cpu_addr = 16'h1234; dma_addr = 16'hABCD;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got %b expected 0", cpu_hold); end
    vectors++; if (dma_hlda !== 1'b0) begin miscompares++; $display("FAIL reset_hlda: got %b expected 0", dma_hlda); end
    vectors++; if (dma_owner !== 1'b0) begin miscompares++; $display("FAIL reset_owner: got %b expected 0", dma_owner); end
    vectors++; if (stat_stolen !== 16'h0) begin miscompares++; $display("FAIL reset_stat: got %h expected 0000", stat_stolen); end
    vectors++; if (mem_addr !== 16'h1234) begin miscompares++; $display("FAIL reset_addr: got %h expected 1234", mem_addr); end
    vectors++; if (mem_rd_n !== 1'b1 || mem_wr_n !== 1'b1) begin miscompares++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 1 1", mem_rd_n, mem_wr_n); end
    reset = 0; cpu_rd_n = 0;
    step();
    vectors++; if (mem_rd_n !== 1'b0) begin miscompares++; $display("FAIL cpu_rd_pass: got %b expected 0", mem_rd_n); end
    cpu_rd_n = 1;
  endtask

  task automatic test_grant_timing();
    for (int t = 1; t <= 14; t++) begin
      dma_hrq = (t >= 10);
      step();
      vectors++; if (cpu_hold !== logic'(t >= 10)) begin miscompares++; $display("FAIL grant_hold t=%0d: got %b expected %b", t, cpu_hold, t >= 10); end
      vectors++; if (dma_owner !== logic'(t >= 11)) begin miscompares++; $display("FAIL grant_owner t=%0d: got %b expected %b", t, dma_owner, t >= 11); end
      vectors++; if (dma_hlda !== logic'(t >= 12)) begin miscompares++; $display("FAIL grant_hlda t=%0d: got %b expected %b", t, dma_hlda, t >= 12); end
    end
    cpu_rd_n = 0; dma_hrq = 0;
    step();
    vectors++; if (dma_hlda !== 1'b0 || cpu_hold !== 1'b1) begin miscompares++; $display("FAIL release_m: got hlda=%b hold=%b expected 0 1", dma_hlda, cpu_hold); end
    vectors++; if (mem_rd_n !== 1'b1) begin miscompares++; $display("FAIL return_mask: got %b expected 1", mem_rd_n); end
    step();
    vectors++; if (cpu_hold !== 1'b0 || dma_owner !== 1'b0) begin miscompares++; $display("FAIL release_done: got hold=%b owner=%b expected 0 0", cpu_hold, dma_owner); end
    vectors++; if (mem_rd_n !== 1'b0) begin miscompares++; $display("FAIL cpu_resume_rd: got %b expected 0", mem_rd_n); end
    cpu_rd_n = 1;
  endtask

  task automatic test_busy_drain();
    cpu_addr = 16'h0F00; dma_addr = 16'h5555; cpu_rd_n = 0;
    dma_hrq = 1; cpu_busy = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if (cpu_hold !== 1'b1 || dma_hlda !== 1'b0 || dma_owner !== 1'b0) begin miscompares++; $display("FAIL drain_hold i=%0d: got hold=%b hlda=%b owner=%b expected 1 0 0", i, cpu_hold, dma_hlda, dma_owner); end
      vectors++; if (mem_rd_n !== 1'b0 || mem_addr !== 16'h0F00) begin miscompares++; $display("FAIL drain_cpu_pass i=%0d: got rd=%b addr=%h expected 0 0f00", i, mem_rd_n, mem_addr); end
    end
    cpu_busy = 0;
    step();
    vectors++; if (dma_hlda !== 1'b0 || dma_owner !== 1'b1 || mem_rd_n !== 1'b1) begin miscompares++; $display("FAIL settle: got hlda=%b owner=%b rd=%b expected 0 1 1", dma_hlda, dma_owner, mem_rd_n); end
    step();
    vectors++; if (dma_hlda !== 1'b1 || mem_addr !== 16'h5555) begin miscompares++; $display("FAIL drain_grant: got hlda=%b addr=%h expected 1 5555", dma_hlda, mem_addr); end
    dma_hrq = 0; cpu_rd_n = 1;
    repeat (2) step();
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL drain_release: got %b expected 0", cpu_hold); end
  endtask

  task automatic test_hrq_pulse();
    int s0;
    s0 = m_stolen;
    cpu_busy = 1; dma_hrq = 1;
    step();
    vectors++; if (cpu_hold !== 1'b1 || dma_hlda !== 1'b0) begin miscompares++; $display("FAIL pulse_hold: got hold=%b hlda=%b expected 1 0", cpu_hold, dma_hlda); end
    dma_hrq = 0;
    step();
    vectors++; if (cpu_hold !== 1'b0 || dma_hlda !== 1'b0 || dma_owner !== 1'b0) begin miscompares++; $display("FAIL pulse_back: got hold=%b hlda=%b owner=%b expected 0 0 0", cpu_hold, dma_hlda, dma_owner); end
    step();
    vectors++; if (stat_stolen !== 16'(s0)) begin miscompares++; $display("FAIL pulse_stat: got %h expected %h", stat_stolen, 16'(s0)); end
    cpu_busy = 0;
  endtask

  task automatic test_dma_burst();
    int s0;
    cpu_addr = 16'h2000; cpu_wr_n = 0; cpu_rd_n = 0;
    dma_addr = 16'hE6D0; dma_rd_n = 0; dma_wr_n = 1;
    dma_hrq = 1;
    repeat (3) step();
    vectors++; if (dma_hlda !== 1'b1) begin miscompares++; $display("FAIL burst_grant: got %b expected 1", dma_hlda); end
    s0 = m_stolen;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (mem_addr !== 16'hE6D0 || mem_rd_n !== 1'b0 || mem_wr_n !== 1'b1) begin miscompares++; $display("FAIL burst_mux i=%0d: got addr=%h rd=%b wr=%b expected e6d0 0 1", i, mem_addr, mem_rd_n, mem_wr_n); end
      step();
    end
    vectors++; if (stat_stolen !== 16'(s0 + 5)) begin miscompares++; $display("FAIL burst_stat: got %h expected %h", stat_stolen, 16'(s0 + 5)); end
    dma_hrq = 0;
    step();
    vectors++; if (mem_rd_n !== 1'b1 || mem_wr_n !== 1'b1) begin miscompares++; $display("FAIL burst_return: got rd=%b wr=%b expected 1 1", mem_rd_n, mem_wr_n); end
    step();
    vectors++; if (mem_wr_n !== 1'b0 || mem_addr !== 16'h2000) begin miscompares++; $display("FAIL burst_cpu_back: got wr=%b addr=%h expected 0 2000", mem_wr_n, mem_addr); end
    idle_inputs();
  endtask

  task automatic test_reset_in_dma();
    cpu_addr = 16'h3C3C; dma_addr = 16'h7777; dma_hrq = 1;
    repeat (5) step();
    vectors++; if (dma_hlda !== 1'b1) begin miscompares++; $display("FAIL pre_reset_grant: got %b expected 1", dma_hlda); end
    #2 reset = 1;
    #1;
    vectors++; if (dma_hlda !== 1'b0 || cpu_hold !== 1'b0 || dma_owner !== 1'b0) begin miscompares++; $display("FAIL async_reset: got hlda=%b hold=%b owner=%b expected 0 0 0", dma_hlda, cpu_hold, dma_owner); end
    vectors++; if (stat_stolen !== 16'h0 || mem_addr !== 16'h3C3C) begin miscompares++; $display("FAIL async_reset_stat: got stat=%h addr=%h expected 0000 3c3c", stat_stolen, mem_addr); end
    model_reset();
    @(negedge clk);
    reset = 0; dma_hrq = 0;
    step();
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL after_reset_hold: got %b expected 0", cpu_hold); end
  endtask

  task automatic test_saturation();
    dma_hrq = 1;
    repeat (3) step();
    for (int i = 0; i < 70000 && m_stolen < 65534; i++) step();
    vectors++; if (stat_stolen !== 16'hFFFE) begin miscompares++; $display("FAIL sat_fffe: got %h expected fffe", stat_stolen); end
    repeat (3) step();
    vectors++; if (stat_stolen !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h expected ffff", stat_stolen); end
    stat_clr = 1;
    step();
    vectors++; if (stat_stolen !== 16'h0000) begin miscompares++; $display("FAIL clr_priority: got %h expected 0000", stat_stolen); end
    stat_clr = 0;
    step();
    vectors++; if (stat_stolen !== 16'h0001) begin miscompares++; $display("FAIL clr_resume: got %h expected 0001", stat_stolen); end
    dma_hrq = 0;
    repeat (2) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      ce       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dma_hrq = ~dma_hrq;
      cpu_busy = 1'($urandom_range(0, 1));
      cpu_addr = 16'($urandom);
      dma_addr = 16'($urandom);
      cpu_wr_n = 1'($urandom_range(0, 1));
      cpu_rd_n = 1'($urandom_range(0, 1));
      dma_wr_n = 1'($urandom_range(0, 1));
      dma_rd_n = 1'($urandom_range(0, 1));
      stat_clr = ($urandom_range(0, 63) == 0);
      step();
      vectors++; if (cpu_hold !== logic'(m_hold)) begin miscompares++; $display("FAIL rnd_hold i=%0d: got %b expected %b", i, cpu_hold, m_hold); end
      vectors++; if (dma_hlda !== logic'(m_grant)) begin miscompares++; $display("FAIL rnd_hlda i=%0d: got %b expected %b", i, dma_hlda, m_grant); end
      vectors++; if (dma_owner !== logic'(m_owner())) begin miscompares++; $display("FAIL rnd_owner i=%0d: got %b expected %b", i, dma_owner, m_owner()); end
      vectors++; if (mem_addr !== exp_addr()) begin miscompares++; $display("FAIL rnd_addr i=%0d: got %h expected %h", i, mem_addr, exp_addr()); end
      vectors++; if (mem_rd_n !== exp_rd_n()) begin miscompares++; $display("FAIL rnd_rd i=%0d: got %b expected %b", i, mem_rd_n, exp_rd_n()); end
      vectors++; if (mem_wr_n !== exp_wr_n()) begin miscompares++; $display("FAIL rnd_wr i=%0d: got %b expected %b", i, mem_wr_n, exp_wr_n()); end
      vectors++; if (stat_stolen !== 16'(m_stolen)) begin miscompares++; $display("FAIL rnd_stat i=%0d: got %h expected %h", i, stat_stolen, 16'(m_stolen)); end
    end
  endtask

  initial begin
    test_reset();
    test_grant_timing();
    test_busy_drain();
    test_hrq_pulse();
    test_dma_burst();
    test_reset_in_dma();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
